rv32_decoder_pipe: RTL and testbench

- Next-generation RV32 decode stage with a valid/ready handshake, flush, and an optional skid buffer.
- Decodes RV32I, plus the M extension when enabled, into one-hot ALU, MDU and opcode vectors, with full illegal-instruction and SYSTEM decode.
- Adds hazard-unit hints: rd write-enable and rs1/rs2 usage.
- Sits between fetch (upstream, carries PC) and execute (downstream).

---
 rtl/rv32_decoder_pipe_if.sv | 46 ++++
 rtl/rv32_decoder_pipe.sv | 250 +++++++++++++++++++++++++
 tb/tb_rv32_decoder_pipe.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_decoder_pipe_if.sv
// Fetch-to-execute bundle interface for the RV32 decode stage.
// The decoder takes the slave side; fetch/execute (or a bench) take the master side.
interface rv32_decoder_pipe_if #(
  parameter int PC_W = 32
);
  logic            i_flush;
  logic            i_valid;
  logic            o_ready;
  logic [31:0]     i_inst;
  logic [PC_W-1:0] i_pc;
  logic            o_valid;
  logic            i_ready;
  logic [PC_W-1:0] o_pc;
  logic [4:0]      o_rs1_addr;
  logic [4:0]      o_rs2_addr;
  logic [4:0]      o_rd_addr;
  logic [31:0]     o_imm;
  logic [2:0]      o_funct3;
  logic [13:0]     o_alu_op;
  logic [7:0]      o_mdu_op;
  logic [10:0]     o_opcode;
  logic            o_rd_we;
  logic            o_rs1_used;
  logic            o_rs2_used;
  logic            o_is_inst_illegal;
  logic            o_is_ecall;
  logic            o_is_ebreak;
  logic            o_is_mret;
  logic            o_is_wfi;

  modport slave (
    input  i_flush, i_valid, i_inst, i_pc, i_ready,
    output o_ready, o_valid, o_pc, o_rs1_addr, o_rs2_addr, o_rd_addr, o_imm,
           o_funct3, o_alu_op, o_mdu_op, o_opcode, o_rd_we, o_rs1_used,
           o_rs2_used, o_is_inst_illegal, o_is_ecall, o_is_ebreak, o_is_mret,
           o_is_wfi
  );

  modport master (
    output i_flush, i_valid, i_inst, i_pc, i_ready,
    input  o_ready, o_valid, o_pc, o_rs1_addr, o_rs2_addr, o_rd_addr, o_imm,
           o_funct3, o_alu_op, o_mdu_op, o_opcode, o_rd_we, o_rs1_used,
           o_rs2_used, o_is_inst_illegal, o_is_ecall, o_is_ebreak, o_is_mret,
           o_is_wfi
  );
endinterface

// File: rtl/rv32_decoder_pipe.sv
// RV32I(+M) decode stage: combinational decode registered into an output stage,
// with an optional one-entry skid buffer so o_ready can be a plain register.
module rv32_decoder_pipe #(
  parameter bit ENABLE_M = 1'b1,
  parameter bit SKID     = 1'b1,
  parameter int PC_W     = 32
) (
  input logic               i_clk,
  input logic               i_rst_n,
  rv32_decoder_pipe_if.slave bus
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [2:0]      funct3;
    logic [13:0]     alu;
    logic [7:0]      mdu;
    logic [10:0]     opc;
    logic            rd_we;
    logic            rs1_used;
    logic            rs2_used;
    logic            illegal;
    logic            ecall;
    logic            ebreak;
    logic            mret;
    logic            wfi;
  } bundle_t;

  // alt selects sub for funct3=000 and sra for funct3=101
  function automatic logic [13:0] alu_arith(input logic [2:0] f3, input logic alt);
    logic [13:0] v;
    case (f3)
      3'b000:  v = alt ? 14'h0002 : 14'h0001;
      3'b001:  v = 14'h0080;
      3'b010:  v = 14'h0004;
      3'b011:  v = 14'h0008;
      3'b100:  v = 14'h0010;
      3'b101:  v = alt ? 14'h0200 : 14'h0100;
      3'b110:  v = 14'h0020;
      3'b111:  v = 14'h0040;
      default: v = 14'h0000;
    endcase
    return v;
  endfunction

  function automatic logic [13:0] alu_branch(input logic [2:0] f3);
    logic [13:0] v;
    case (f3)
      3'b000:  v = 14'h0400;
      3'b001:  v = 14'h0800;
      3'b100:  v = 14'h0004;
      3'b101:  v = 14'h1000;
      3'b110:  v = 14'h0008;
      3'b111:  v = 14'h2000;
      default: v = 14'h0000;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] imm_i(input logic [31:0] w);
    return {{20{w[31]}}, w[31:20]};
  endfunction

  function automatic logic [31:0] imm_st(input logic [31:0] w);
    return {{20{w[31]}}, w[31:25], w[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  logic [31:0] inst_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  logic [11:0] sys_s;
  logic [10:0] opc_s;
  logic [13:0] alu_s;
  logic [7:0]  mdu_s;
  logic [31:0] imm_s;
  logic        bad_s;
  logic        legal_s;
  bundle_t     dec_s;

  bundle_t     out_r;
  bundle_t     skid_r;
  logic        out_valid_r;
  logic        skid_valid_r;
  logic        ready_r;
  logic        out_free_s;
  logic        accept_s;

  assign inst_s = bus.i_inst;
  assign f3_s   = inst_s[14:12];
  assign f7_s   = inst_s[31:25];
  assign sys_s  = inst_s[31:20];

  // Opcode class, ALU/MDU selection, immediate format and illegal detection
  always_comb begin
    opc_s = 11'd0;
    alu_s = 14'd0;
    mdu_s = 8'd0;
    imm_s = 32'd0;
    bad_s = 1'b0;
    case (inst_s[6:0])
      OP_R: begin
        opc_s[0] = 1'b1;
        if (f7_s == 7'b0000001) begin
          mdu_s = 8'd1 << f3_s;
          bad_s = !ENABLE_M;
        end else if (f7_s == 7'b0100000) begin
          alu_s = alu_arith(f3_s, 1'b1);
          bad_s = !((f3_s == 3'b000) || (f3_s == 3'b101));
        end else if (f7_s == 7'b0000000) begin
          alu_s = alu_arith(f3_s, 1'b0);
        end else begin
          bad_s = 1'b1;
        end
      end
      OP_I: begin
        opc_s[1] = 1'b1;
        alu_s    = alu_arith(f3_s, (f3_s == 3'b101) && inst_s[30]);
        imm_s    = imm_i(inst_s);
        bad_s    = ((f3_s == 3'b001) || (f3_s == 3'b101)) && inst_s[25];
      end
      OP_LOAD:   begin opc_s[2]  = 1'b1; alu_s = 14'h0001; imm_s = imm_i(inst_s); end
      OP_STORE:  begin opc_s[3]  = 1'b1; alu_s = 14'h0001; imm_s = imm_st(inst_s); end
      OP_BRANCH: begin opc_s[4]  = 1'b1; alu_s = alu_branch(f3_s); imm_s = imm_b(inst_s); end
      OP_JAL:    begin opc_s[5]  = 1'b1; alu_s = 14'h0001; imm_s = imm_j(inst_s); end
      OP_JALR:   begin opc_s[6]  = 1'b1; alu_s = 14'h0001; imm_s = imm_i(inst_s); end
      OP_LUI:    begin opc_s[7]  = 1'b1; alu_s = 14'h0001; imm_s = {inst_s[31:12], 12'h000}; end
      OP_AUIPC:  begin opc_s[8]  = 1'b1; alu_s = 14'h0001; imm_s = {inst_s[31:12], 12'h000}; end
      OP_SYSTEM: begin
        opc_s[9] = 1'b1;
        alu_s    = 14'h0001;
        imm_s    = {20'd0, sys_s};
        if (f3_s == 3'b100) begin
          bad_s = 1'b1;
        end else if (f3_s == 3'b000) begin
          bad_s = !((sys_s == 12'h000) || (sys_s == 12'h001) ||
                    (sys_s == 12'h302) || (sys_s == 12'h105));
        end else begin
          bad_s = 1'b0;
        end
      end
      OP_FENCE:  begin opc_s[10] = 1'b1; alu_s = 14'h0001; imm_s = {20'd0, sys_s}; end
      default:   bad_s = 1'b1;
    endcase
  end

  assign legal_s = !bad_s;

  // Assemble the decoded bundle; illegal words keep pc/imm/fields but no control
  always_comb begin
    dec_s          = '0;
    dec_s.pc       = bus.i_pc;
    dec_s.rs1      = inst_s[19:15];
    dec_s.rs2      = inst_s[24:20];
    dec_s.rd       = inst_s[11:7];
    dec_s.imm      = imm_s;
    dec_s.funct3   = f3_s;
    dec_s.illegal  = bad_s;
    dec_s.alu      = legal_s ? alu_s : 14'd0;
    dec_s.mdu      = legal_s ? mdu_s : 8'd0;
    dec_s.opc      = legal_s ? opc_s : 11'd0;
    dec_s.rd_we    = legal_s && (inst_s[11:7] != 5'd0) &&
                     ((|opc_s[2:0]) || (|opc_s[8:5]) || (opc_s[9] && (f3_s != 3'b000)));
    dec_s.rs1_used = legal_s && ((|opc_s[4:0]) || opc_s[6] ||
                     (opc_s[9] && (f3_s != 3'b000) && !f3_s[2]));
    dec_s.rs2_used = legal_s && (opc_s[0] || opc_s[3] || opc_s[4]);
    dec_s.ecall    = legal_s && opc_s[9] && (f3_s == 3'b000) && (sys_s == 12'h000);
    dec_s.ebreak   = legal_s && opc_s[9] && (f3_s == 3'b000) && (sys_s == 12'h001);
    dec_s.mret     = legal_s && opc_s[9] && (f3_s == 3'b000) && (sys_s == 12'h302);
    dec_s.wfi      = legal_s && opc_s[9] && (f3_s == 3'b000) && (sys_s == 12'h105);
  end

  assign out_free_s = !out_valid_r || bus.i_ready;
  assign accept_s   = bus.i_valid && bus.o_ready;
  assign bus.o_ready = SKID ? ready_r : (ready_r && out_free_s);

  // Output stage and skid entry; ready_r tracks "skid entry free next cycle"
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_r        <= '0;
      skid_r       <= '0;
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      ready_r      <= 1'b0;
    end else if (bus.i_flush) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      ready_r      <= 1'b1;
    end else begin
      if (out_free_s) begin
        if (skid_valid_r) begin
          out_r       <= skid_r;
          out_valid_r <= 1'b1;
        end else begin
          out_valid_r <= accept_s;
          if (accept_s) out_r <= dec_s;
        end
        skid_valid_r <= 1'b0;
        ready_r      <= 1'b1;
      end else begin
        if (accept_s) begin
          skid_r       <= dec_s;
          skid_valid_r <= 1'b1;
        end
        ready_r <= !(accept_s || skid_valid_r);
      end
    end
  end

  assign bus.o_valid           = out_valid_r;
  assign bus.o_pc              = out_r.pc;
  assign bus.o_rs1_addr        = out_r.rs1;
  assign bus.o_rs2_addr        = out_r.rs2;
  assign bus.o_rd_addr         = out_r.rd;
  assign bus.o_imm             = out_r.imm;
  assign bus.o_funct3          = out_r.funct3;
  assign bus.o_alu_op          = out_r.alu;
  assign bus.o_mdu_op          = out_r.mdu;
  assign bus.o_opcode          = out_r.opc;
  assign bus.o_rd_we           = out_r.rd_we;
  assign bus.o_rs1_used        = out_r.rs1_used;
  assign bus.o_rs2_used        = out_r.rs2_used;
  assign bus.o_is_inst_illegal = out_r.illegal;
  assign bus.o_is_ecall        = out_r.ecall;
  assign bus.o_is_ebreak       = out_r.ebreak;
  assign bus.o_is_mret         = out_r.mret;
  assign bus.o_is_wfi          = out_r.wfi;
endmodule

// File: tb/tb_rv32_decoder_pipe.sv
// Bench for rv32_decoder_pipe: a skid/M-enabled instance and an M-less, skid-less
// instance share one stimulus stream; each has its own ordered scoreboard.
module tb_rv32_decoder_pipe;
  localparam int BW = 123;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   acc_a;
  logic [BW-1:0] qa[$];
  logic [BW-1:0] qb[$];

  rv32_decoder_pipe_if #(.PC_W(32)) bus_a ();
  rv32_decoder_pipe_if #(.PC_W(32)) bus_b ();

  rv32_decoder_pipe #(.ENABLE_M(1'b1), .SKID(1'b1), .PC_W(32)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));
  rv32_decoder_pipe #(.ENABLE_M(1'b0), .SKID(1'b0), .PC_W(32)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode straight from the ISA rules; returns the bundle without pc.
  function automatic logic [90:0] ref_dec(input logic [31:0] w, input bit en_m);
    int kind, a, m, v;
    bit ill, ec, eb, mr, wf, we, u1, u2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] iimm, imm;
    logic [13:0] one14;
    logic [7:0] one8;
    logic [10:0] one11;
    int rtab[8];
    rtab = '{0, 7, 2, 3, 4, 8, 5, 6};
    one14 = 14'd1; one8 = 8'd1; one11 = 11'd1;
    f3 = w[14:12]; f7 = w[31:25];
    ec = 0; eb = 0; mr = 0; wf = 0; a = 0; m = -1; imm = 32'd0;
    case (w[6:0])
      7'h33: kind = 0;  7'h13: kind = 1;  7'h03: kind = 2;  7'h23: kind = 3;
      7'h63: kind = 4;  7'h6F: kind = 5;  7'h67: kind = 6;  7'h37: kind = 7;
      7'h17: kind = 8;  7'h73: kind = 9;  7'h0F: kind = 10;
      default: kind = -1;
    endcase
    ill = (kind < 0);
    iimm = $signed(w) >>> 20;
    if (kind == 0) begin
      if (f7 == 7'd1) begin m = int'(f3); ill = !en_m; end
      else if (f7 == 7'd32) begin
        ill = !(f3 == 3'd0 || f3 == 3'd5); a = (f3 == 3'd0) ? 1 : 9;
      end else if (f7 == 7'd0) a = rtab[f3];
      else ill = 1;
    end else if (kind == 1) begin
      a = rtab[f3];
      if (f3 == 3'd5 && w[30]) a = 9;
      if ((f3 == 3'd1 || f3 == 3'd5) && w[25]) ill = 1;
    end else if (kind == 4) begin
      case (f3)
        3'd0: a = 10; 3'd1: a = 11; 3'd4: a = 2; 3'd5: a = 12;
        3'd6: a = 3;  3'd7: a = 13; default: a = -1;
      endcase
    end else if (kind == 9) begin
      if (f3 == 3'd4) ill = 1;
      if (f3 == 3'd0) begin
        ec = (w[31:20] == 12'h000); eb = (w[31:20] == 12'h001);
        mr = (w[31:20] == 12'h302); wf = (w[31:20] == 12'h105);
        ill = !(ec || eb || mr || wf);
      end
    end
    case (kind)
      1, 2, 6: imm = iimm;
      3: imm = (iimm & 32'hFFFF_FFE0) | {27'd0, w[11:7]};
      4: begin
        v = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        imm = 32'(v);
      end
      5: begin
        v = (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        imm = 32'(v);
      end
      7, 8: imm = w & 32'hFFFF_F000;
      9, 10: imm = w >> 20;
      default: imm = 32'd0;
    endcase
    we = !ill && (w[11:7] != 5'd0) &&
         (kind inside {0, 1, 2, 5, 6, 7, 8} || (kind == 9 && f3 != 3'd0));
    u1 = !ill && (kind inside {0, 1, 2, 3, 4, 6} || (kind == 9 && f3 inside {3'd1, 3'd2, 3'd3}));
    u2 = !ill && (kind inside {0, 3, 4});
    if (ill) begin ec = 0; eb = 0; mr = 0; wf = 0; end
    return {w[19:15], w[24:20], w[11:7], imm, f3,
            (!ill && m < 0 && a >= 0) ? (one14 << a) : 14'd0,
            (!ill && m >= 0) ? (one8 << m) : 8'd0,
            (!ill) ? (one11 << kind) : 11'd0,
            we, u1, u2, ill, ec, eb, mr, wf};
  endfunction

  function automatic logic [BW-1:0] vec_a();
    return {bus_a.o_pc, bus_a.o_rs1_addr, bus_a.o_rs2_addr, bus_a.o_rd_addr, bus_a.o_imm,
            bus_a.o_funct3, bus_a.o_alu_op, bus_a.o_mdu_op, bus_a.o_opcode, bus_a.o_rd_we,
            bus_a.o_rs1_used, bus_a.o_rs2_used, bus_a.o_is_inst_illegal, bus_a.o_is_ecall,
            bus_a.o_is_ebreak, bus_a.o_is_mret, bus_a.o_is_wfi};
  endfunction

  function automatic logic [BW-1:0] vec_b();
    return {bus_b.o_pc, bus_b.o_rs1_addr, bus_b.o_rs2_addr, bus_b.o_rd_addr, bus_b.o_imm,
            bus_b.o_funct3, bus_b.o_alu_op, bus_b.o_mdu_op, bus_b.o_opcode, bus_b.o_rd_we,
            bus_b.o_rs1_used, bus_b.o_rs2_used, bus_b.o_is_inst_illegal, bus_b.o_is_ecall,
            bus_b.o_is_ebreak, bus_b.o_is_mret, bus_b.o_is_wfi};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                        input bit rdy, input bit fl);
    bus_a.i_valid = v; bus_a.i_inst = inst; bus_a.i_pc = pc; bus_a.i_ready = rdy; bus_a.i_flush = fl;
    bus_b.i_valid = v; bus_b.i_inst = inst; bus_b.i_pc = pc; bus_b.i_ready = rdy; bus_b.i_flush = fl;
  endtask

  // Pre-edge view of both handshakes: check heads, pop on transfer, push on accept.
  task automatic sb_eval();
    if (bus_a.o_valid) begin
      chk("a_sb_nonempty", 128'(qa.size() != 0), 128'd1);
      if (qa.size() != 0) begin
        chk("a_bundle", 128'(vec_a()), 128'(qa[0]));
        if (bus_a.i_ready) void'(qa.pop_front());
      end
    end
    if (bus_b.o_valid) begin
      chk("b_sb_nonempty", 128'(qb.size() != 0), 128'd1);
      if (qb.size() != 0) begin
        chk("b_bundle", 128'(vec_b()), 128'(qb[0]));
        if (bus_b.i_ready) void'(qb.pop_front());
      end
    end
    acc_a = bus_a.i_valid && bus_a.o_ready && !bus_a.i_flush;
    if (bus_a.i_flush) qa.delete();
    else if (acc_a) qa.push_back({bus_a.i_pc, ref_dec(bus_a.i_inst, 1'b1)});
    if (bus_b.i_flush) qb.delete();
    else if (bus_b.i_valid && bus_b.o_ready) qb.push_back({bus_b.i_pc, ref_dec(bus_b.i_inst, 1'b0)});
  endtask

  task automatic tick();
    @(negedge clk);
    sb_eval();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;  3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;  5: w[6:0] = 7'h6F;  6: w[6:0] = 7'h67;  7: w[6:0] = 7'h37;
      8: w[6:0] = 7'h17;  9: w[6:0] = 7'h73;  10: w[6:0] = 7'h0F;
      default: w[6:0] = w[6:0];
    endcase
    if (k == 0) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'd0; 1: w[31:25] = 7'd32; 2: w[31:25] = 7'd1;
        default: w[31:25] = w[31:25];
      endcase
    end
    if (k == 9 && $urandom_range(0, 1) == 1) begin
      w[14:12] = 3'd0;
      case ($urandom_range(0, 4))
        0: w[31:20] = 12'h000; 1: w[31:20] = 12'h001; 2: w[31:20] = 12'h302;
        3: w[31:20] = 12'h105; default: w[31:20] = w[31:20];
      endcase
    end
    return w;
  endfunction

  logic [31:0] skid_insts[4];
  logic [31:0] sys_words[5];
  logic [4:0]  sys_flags[5];
  int idx;

  initial begin
    checks = 0; errors = 0; acc_a = 0;
    skid_insts = '{32'h00108093, 32'h00210113, 32'h003181B3, 32'h40418233};
    sys_words  = '{32'h00000073, 32'h00100073, 32'h30200073, 32'h10500073, 32'h00200073};
    sys_flags  = '{5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};
    rst_n = 1'b0;
    set_in(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    chk("rst_a_out", 128'(vec_a()), 128'd0);
    chk("rst_a_valid_ready", {126'd0, bus_a.o_valid, bus_a.o_ready}, 128'd0);
    chk("rst_b_valid_ready", {126'd0, bus_b.o_valid, bus_b.o_ready}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst_a", 128'(bus_a.o_ready), 128'd1);
    chk("ready_after_rst_b", 128'(bus_b.o_ready), 128'd1);

    // add / sub / mul stream at full throughput
    set_in(1'b1, 32'h002081B3, 32'h100, 1'b1, 1'b0); tick();
    chk("add_valid", 128'(bus_a.o_valid), 128'd1);
    chk("add_alu", 128'(bus_a.o_alu_op), 128'h1);
    chk("add_rd", {121'd0, bus_a.o_rd_we, bus_a.o_rd_addr, bus_a.o_pc[7:0]}, {121'd0, 1'b1, 5'd3, 8'h00} | 128'h100);
    set_in(1'b1, 32'h402081B3, 32'h104, 1'b1, 1'b0); tick();
    chk("sub_alu", 128'(bus_a.o_alu_op), 128'h2);
    chk("sub_pc", 128'(bus_a.o_pc), 128'h104);
    set_in(1'b1, 32'h022081B3, 32'h108, 1'b1, 1'b0); tick();
    chk("mul_mdu_alu", {bus_a.o_mdu_op, bus_a.o_alu_op}, {8'h01, 14'h0});
    chk("mul_nom_illegal", {bus_b.o_is_inst_illegal, bus_b.o_mdu_op, bus_b.o_rd_we}, {1'b1, 8'h00, 1'b0});
    set_in(1'b0, 32'd0, 32'd0, 1'b1, 1'b0); tick();
    chk("stream_end", 128'(bus_a.o_valid), 128'd0);

    // skid fill: output stalled two cycles, then in-order drain
    idx = 0;
    for (int n = 0; n < 16 && idx < 4; n++) begin
      set_in(1'b1, skid_insts[idx], 32'h200 + 32'(idx * 4), (n >= 2), 1'b0);
      tick();
      if (acc_a) idx++;
      if (n == 1) begin
        chk("skid_full_ready", 128'(bus_a.o_ready), 128'd0);
        chk("skid_hold", {bus_a.o_valid, bus_a.o_pc}, {1'b1, 32'h200});
      end
    end
    chk("skid_all_accepted", 128'(idx), 128'd4);
    set_in(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    repeat (3) tick();
    chk("skid_drained", 128'(qa.size()), 128'd0);

    // directed decode corners
    set_in(1'b1, 32'h02009093, 32'h300, 1'b1, 1'b0); tick();
    chk("slli_illegal", {bus_a.o_is_inst_illegal, bus_a.o_opcode}, {1'b1, 11'd0});
    set_in(1'b1, 32'hFE000EE3, 32'h304, 1'b1, 1'b0); tick();
    chk("beq", {bus_a.o_alu_op, bus_a.o_imm}, {14'h0400, 32'hFFFF_FFFC});
    set_in(1'b1, 32'h123452B7, 32'h308, 1'b1, 1'b0); tick();
    chk("lui", {bus_a.o_imm, bus_a.o_rd_addr}, {32'h1234_5000, 5'd5});
    for (int s = 0; s < 5; s++) begin
      set_in(1'b1, sys_words[s], 32'h400 + 32'(s * 4), 1'b1, 1'b0); tick();
      chk("system_flags", {bus_a.o_is_inst_illegal, bus_a.o_is_ecall, bus_a.o_is_ebreak,
                           bus_a.o_is_mret, bus_a.o_is_wfi}, 128'(sys_flags[s]));
    end

    // flush with skid full and a live input
    set_in(1'b1, 32'h00500293, 32'h500, 1'b0, 1'b0); tick();
    set_in(1'b1, 32'h00600313, 32'h504, 1'b0, 1'b0); tick();
    set_in(1'b1, 32'h00700393, 32'hDEAD0, 1'b0, 1'b1); tick();
    chk("flush_a", {bus_a.o_valid, bus_a.o_ready}, {1'b0, 1'b1});
    chk("flush_b", 128'(bus_b.o_valid), 128'd0);
    set_in(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    repeat (3) tick();

    // randomized traffic with stalls and rare flushes
    for (int r = 0; r < 400; r++) begin
      set_in($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom_range(0, 9) < 7,
             $urandom_range(0, 49) == 0);
      tick();
    end
    set_in(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    repeat (4) tick();
    chk("final_empty_a", 128'(qa.size()), 128'd0);
    chk("final_empty_b", 128'(qb.size()), 128'd0);

    // asynchronous reset in the middle of a stall
    set_in(1'b1, 32'h00108093, 32'h600, 1'b0, 1'b0); tick();
    set_in(1'b1, 32'h00210113, 32'h604, 1'b0, 1'b0); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a", {bus_a.o_valid, bus_a.o_ready, vec_a()}, 128'd0);
    chk("async_rst_b", {bus_b.o_valid, bus_b.o_ready, vec_b()}, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
